fht_input_loader: RTL and testbench

The loader sits directly upstream of the FHT control/butterfly datapath. It accepts a serial stream of N = 4·2^A_BIT real samples and writes each one into one of the 4 data RAM banks at its bit-reversed position. When the frame is complete, it pulses the start input of the FHT controller. It then holds off new input until the controller reports the transform finished, so the banks are never overwritten while a transform is running.

---
 rtl/fht_input_loader.sv | 149 ++++++++++++++
 tb/tb_fht_input_loader.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fht_input_loader.sv
// fht_input_loader
//
// Collects one frame of N = 2^(A_BIT+2) real samples from a valid/ready
// stream. Each sample is written into one of four RAM banks at its
// bit-reversed position. Once the frame is complete, the loader pulses the
// FHT controller start input. It then refuses new samples until the
// controller reports completion, so the banks stay stable during a transform.
//
// Ports
//   iCLK      clock, rising-edge active
//   iRESET    asynchronous active-low reset
//   iVALID    sample present on iDATA
//   iDATA     sample, natural order, index 0 first
//   oREADY    loader accepts a sample this cycle (transfer = iVALID & oREADY)
//   oDATA_WR  write data, shared by all four banks
//   oADDR_WR  write address, shared by all four banks
//   oWE       one-hot bank write enable, bit b drives bank b
//   oSTART    one-cycle start pulse to the FHT controller
//   iFHT_RDY  controller idle flag (1 = idle/done, 0 = transform running)
//   oBUSY     high whenever the loader is not accepting a frame
//   oCNT      samples accepted so far in the current frame

module fht_input_loader #(
    parameter int A_BIT = 8,
    parameter int D_BIT = 16
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic               iVALID,
    input  logic [D_BIT-1:0]   iDATA,
    output logic               oREADY,
    output logic [D_BIT-1:0]   oDATA_WR,
    output logic [A_BIT-1:0]   oADDR_WR,
    output logic [3:0]         oWE,
    output logic               oSTART,
    input  logic               iFHT_RDY,
    output logic               oBUSY,
    output logic [A_BIT+1:0]   oCNT
);

    localparam int C_BIT = A_BIT + 2;

    typedef enum logic [2:0] {
        LOAD,
        DRAIN,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [C_BIT-1:0]   cnt;
    logic [C_BIT-1:0]   cnt_rev;
    logic               xfer;
    logic               last;

    assign xfer = iVALID && oREADY;
    assign last = (cnt == {C_BIT{1'b1}});
    assign oCNT = cnt;

    // The sample index reversed over all A_BIT+2 bits. The top two bits pick
    // the bank, and the remaining bits form the in-bank address.
    always_comb begin
        cnt_rev = '0;
        for (int i = 0; i < C_BIT; i++) begin
            cnt_rev[i] = cnt[C_BIT-1-i];
        end
    end

    // State register.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs. DRAIN is a one-cycle gap that
    // puts the final registered write on the bus before START is raised.
    // The controller therefore cannot begin reading a bank that is still
    // being written.
    always_comb begin
        state_nxt = state;
        oREADY    = 1'b0;
        oSTART    = 1'b0;
        oBUSY     = 1'b1;
        unique case (state)
            LOAD: begin
                oREADY = 1'b1;
                oBUSY  = 1'b0;
                if (xfer && last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = START;
            end
            START: begin
                oSTART    = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!iFHT_RDY) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (iFHT_RDY) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // Sample counter. It wraps naturally to zero on the last sample of a
    // frame. The explicit clear on leaving WAIT_DONE keeps the next frame
    // aligned to index 0 even if the count were ever disturbed.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            cnt <= '0;
        end else if (xfer) begin
            cnt <= cnt + 1'b1;
        end else if ((state == WAIT_DONE) && iFHT_RDY) begin
            cnt <= '0;
        end
    end

    // Registered write port. Data and address hold their last value between
    // writes. Only the enable is cleared, so idle cycles never write.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            oDATA_WR <= '0;
            oADDR_WR <= '0;
            oWE      <= 4'b0000;
        end else if (xfer) begin
            oDATA_WR <= iDATA;
            oADDR_WR <= cnt_rev[A_BIT-1:0];
            oWE      <= 4'b0001 << cnt_rev[C_BIT-1:A_BIT];
        end else begin
            oWE      <= 4'b0000;
        end
    end

endmodule

// File: tb/tb_fht_input_loader.sv
// tb_fht_input_loader
//
// Drives randomized sample streams and a simple FHT controller handshake
// into fht_input_loader. The results are compared against a frame-level
// reference model of the loader's observable behaviour.

module tb_fht_input_loader;

    localparam int A_BIT = 8;
    localparam int D_BIT = 16;
    localparam int N     = 1024;

    logic               iCLK;
    logic               iRESET;
    logic               iVALID;
    logic [D_BIT-1:0]   iDATA;
    logic               oREADY;
    logic [D_BIT-1:0]   oDATA_WR;
    logic [A_BIT-1:0]   oADDR_WR;
    logic [3:0]         oWE;
    logic               oSTART;
    logic               iFHT_RDY;
    logic               oBUSY;
    logic [A_BIT+1:0]   oCNT;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state: the position within the frame/transform timeline.
    bit           m_loading;
    int           m_cnt;
    int           m_since;
    bit           m_seen_low;
    logic [3:0]   m_we;
    logic [7:0]   m_addr;
    logic [15:0]  m_data;

    int wr_hits [N];

    fht_input_loader #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
        .iCLK     (iCLK),
        .iRESET   (iRESET),
        .iVALID   (iVALID),
        .iDATA    (iDATA),
        .oREADY   (oREADY),
        .oDATA_WR (oDATA_WR),
        .oADDR_WR (oADDR_WR),
        .oWE      (oWE),
        .oSTART   (oSTART),
        .iFHT_RDY (iFHT_RDY),
        .oBUSY    (oBUSY),
        .oCNT     (oCNT)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Keep the run bounded if the design locks up.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Bit reversal over 10 bits, computed arithmetically.
    function automatic int bitrev(input int i);
        int r;
        r = 0;
        for (int b = 0; b < 10; b++) begin
            if (((i >> b) % 2) == 1) r = r + (1 << (9 - b));
        end
        return r;
    endfunction

    function automatic logic [40:0] observed();
        return {oWE, oADDR_WR, oDATA_WR, oCNT, oREADY, oBUSY, oSTART};
    endfunction

    task automatic model_reset();
        m_loading  = 1'b1;
        m_cnt      = 0;
        m_since    = 0;
        m_seen_low = 1'b0;
        m_we       = 4'b0;
        m_addr     = 8'b0;
        m_data     = 16'b0;
    endtask

    // Asserts reset mid-cycle, then releases it away from a clock edge.
    task automatic do_reset();
        iRESET   = 1'b0;
        iVALID   = 1'b0;
        iDATA    = '0;
        iFHT_RDY = 1'b1;
        model_reset();
        @(posedge iCLK);
        #3;
        iRESET = 1'b1;
        @(posedge iCLK);
        #1;
    endtask

    // Applies one cycle of inputs, advances the model across the coming edge,
    // and returns the observed and predicted outputs after that edge.
    task automatic drive_cycle(input bit valid, input logic [15:0] data, input bit rdy,
                               output logic [40:0] act, output logic [40:0] exp,
                               output bit frame_done);
        int r;
        frame_done = 1'b0;
        iVALID   = valid;
        iDATA    = data;
        iFHT_RDY = rdy;
        if (m_loading) begin
            if (valid) begin
                r      = bitrev(m_cnt);
                m_we   = 4'(1 << (r / 256));
                m_addr = 8'(r % 256);
                m_data = data;
                if (m_cnt == N - 1) begin
                    m_cnt      = 0;
                    m_loading  = 1'b0;
                    m_since    = 1;
                    frame_done = 1'b1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                m_we = 4'b0;
            end
        end else begin
            m_we = 4'b0;
            if (m_since == 1) begin
                m_since = 2;
            end else if (m_since == 2) begin
                m_since = 3;
            end else if (!m_seen_low) begin
                if (!rdy) m_seen_low = 1'b1;
            end else if (rdy) begin
                m_loading  = 1'b1;
                m_seen_low = 1'b0;
                m_since    = 0;
            end
        end
        @(posedge iCLK);
        #1;
        act = observed();
        exp = {m_we, m_addr, m_data, m_cnt[9:0], m_loading, !m_loading,
               (!m_loading && m_since == 2)};
    endtask

    // Runs one complete frame followed by a controller handshake.
    // iVALID has the given duty in percent throughout. The controller drops
    // iFHT_RDY the cycle after START and holds it low for busy_len cycles.
    task automatic run_frame(input int duty, input int busy_len,
                             output int writes, output int starts, output int start_gap);
        logic [40:0] act, exp;
        bit   fd, rdy, left_load;
        int   low_left, cyc, last_cyc, widx, bank, r;
        low_left  = -1;
        cyc       = 0;
        last_cyc  = -100;
        widx      = 0;
        left_load = 1'b0;
        writes    = 0;
        starts    = 0;
        start_gap = -1;
        for (int i = 0; i < N; i++) wr_hits[i] = 0;
        forever begin
            if (cyc >= 20000) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL frame_timeout: frame not finished after %0d cycles, required fewer than 20000", cyc);
                break;
            end
            rdy = 1'b1;
            if (!m_loading && m_since >= 3) begin
                if (low_left < 0) low_left = busy_len;
                if (low_left > 0) begin
                    rdy = 1'b0;
                    low_left--;
                end
            end
            drive_cycle($urandom_range(0, 99) < duty, 16'($urandom), rdy, act, exp, fd);
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("[TB] FAIL cycle_outputs: cycle %0d got %h expected %h", cyc, act, exp);
            end
            if (fd) begin
                left_load = 1'b1;
                last_cyc  = cyc;
            end
            if (oWE !== 4'b0000) begin
                writes++;
                case (oWE)
                    4'b0001: bank = 0;
                    4'b0010: bank = 1;
                    4'b0100: bank = 2;
                    4'b1000: bank = 3;
                    default: bank = -1;
                endcase
                r = bitrev(widx % N);
                vectors++;
                if (bank != r / 256 || oADDR_WR !== 8'(r % 256)) begin
                    miscompares++;
                    $display("[TB] FAIL write_order: write %0d got we=%b addr=%0d expected bank %0d addr %0d",
                             widx, oWE, oADDR_WR, r / 256, r % 256);
                end
                if (bank >= 0) wr_hits[bank * 256 + int'(oADDR_WR)]++;
                widx++;
            end
            if (oSTART === 1'b1) begin
                starts++;
                start_gap = cyc + 1 - last_cyc;
            end
            cyc++;
            if (left_load && m_loading) break;
        end
    endtask

    task automatic test_reset();
        logic [40:0] act, exp;
        bit fd;
        $display("[TB] test_reset");
        iRESET = 1'b0;
        #2;
        vectors++;
        if (observed() !== {4'b0, 8'b0, 16'b0, 10'b0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got %h expected %h", observed(),
                     {4'b0, 8'b0, 16'b0, 10'b0, 1'b1, 1'b0, 1'b0});
        end
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, 16'($urandom), 1'b1, act, exp, fd);
            vectors++;
            if (act !== exp || oWE !== 4'b0000 || oCNT !== 10'd0 || oREADY !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL idle_cycle: cycle %0d got %h expected %h", i, act, exp);
            end
        end
    endtask

    task automatic test_bitrev();
        logic [40:0] act, exp;
        bit fd;
        logic [3:0] tbl_we [5];
        logic [7:0] tbl_addr [5];
        logic [15:0] d;
        $display("[TB] test_bitrev");
        tbl_we   = '{4'b0001, 4'b0100, 4'b0010, 4'b1000, 4'b0001};
        tbl_addr = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd128};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            d = 16'($urandom);
            drive_cycle(1'b1, d, 1'b1, act, exp, fd);
            vectors++;
            if (act !== exp || oWE !== tbl_we[i] || oADDR_WR !== tbl_addr[i] || oDATA_WR !== d) begin
                miscompares++;
                $display("[TB] FAIL bitrev_write: index %0d got we=%b addr=%0d data=%h expected we=%b addr=%0d data=%h",
                         i, oWE, oADDR_WR, oDATA_WR, tbl_we[i], tbl_addr[i], d);
            end
        end
        drive_cycle(1'b0, 16'h0, 1'b1, act, exp, fd);
        vectors++;
        if (act !== exp || oWE !== 4'b0000 || oCNT !== 10'd5) begin
            miscompares++;
            $display("[TB] FAIL bitrev_idle: got we=%b cnt=%0d expected we=0000 cnt=5", oWE, oCNT);
        end
    endtask

    task automatic test_full_frame();
        int writes, starts, gap;
        int bank_cnt [4];
        bit once;
        logic [40:0] act, exp;
        bit fd;
        $display("[TB] test_full_frame");
        do_reset();
        run_frame(100, 5000, writes, starts, gap);
        bank_cnt = '{0, 0, 0, 0};
        once = 1'b1;
        for (int i = 0; i < N; i++) begin
            bank_cnt[i / 256] += wr_hits[i];
            if (wr_hits[i] != 1) once = 1'b0;
        end
        vectors++;
        if (writes != N || !once) begin
            miscompares++;
            $display("[TB] FAIL frame_writes: got %0d writes (each address once=%0d) expected %0d writes once each",
                     writes, once, N);
        end
        for (int b = 0; b < 4; b++) begin
            vectors++;
            if (bank_cnt[b] != 256) begin
                miscompares++;
                $display("[TB] FAIL bank_writes: bank %0d got %0d expected 256", b, bank_cnt[b]);
            end
        end
        vectors++;
        if (starts != 1 || gap != 2) begin
            miscompares++;
            $display("[TB] FAIL start_pulse: got %0d pulses at gap %0d expected 1 pulse at gap 2", starts, gap);
        end
        drive_cycle(1'b1, 16'hBEEF, 1'b1, act, exp, fd);
        vectors++;
        if (act !== exp || oWE !== 4'b0001 || oADDR_WR !== 8'd0 || oDATA_WR !== 16'hBEEF) begin
            miscompares++;
            $display("[TB] FAIL next_frame_first: got we=%b addr=%0d data=%h expected we=0001 addr=0 data=beef",
                     oWE, oADDR_WR, oDATA_WR);
        end
    endtask

    task automatic test_random_gaps();
        int writes, starts, gap;
        $display("[TB] test_random_gaps");
        do_reset();
        run_frame(50, 30, writes, starts, gap);
        vectors++;
        if (writes != N || starts != 1 || gap != 2) begin
            miscompares++;
            $display("[TB] FAIL gap_frame: got writes=%0d starts=%0d gap=%0d expected writes=%0d starts=1 gap=2",
                     writes, starts, gap, N);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [40:0] act, exp;
        bit fd;
        int writes, starts, gap, early_starts;
        $display("[TB] test_reset_mid_frame");
        do_reset();
        early_starts = 0;
        for (int i = 0; i < 300; i++) begin
            drive_cycle(1'b1, 16'($urandom), 1'b1, act, exp, fd);
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("[TB] FAIL partial_frame: index %0d got %h expected %h", i, act, exp);
            end
            if (oSTART === 1'b1) early_starts++;
        end
        iRESET = 1'b0;
        #2;
        vectors++;
        if (observed() !== {4'b0, 8'b0, 16'b0, 10'b0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_values: got %h expected %h", observed(),
                     {4'b0, 8'b0, 16'b0, 10'b0, 1'b1, 1'b0, 1'b0});
        end
        do_reset();
        run_frame(100, 10, writes, starts, gap);
        vectors++;
        if (early_starts != 0 || writes != N || starts != 1 || gap != 2) begin
            miscompares++;
            $display("[TB] FAIL post_reset_frame: got early=%0d writes=%0d starts=%0d gap=%0d expected early=0 writes=%0d starts=1 gap=2",
                     early_starts, writes, starts, gap, N);
        end
    endtask

    initial begin
        iRESET   = 1'b0;
        iVALID   = 1'b0;
        iDATA    = '0;
        iFHT_RDY = 1'b1;
        model_reset();
        test_reset();
        test_bitrev();
        test_full_frame();
        test_random_gaps();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
